// File: rtl/mips32_multicycle_ctrl.sv
// Multicycle MIPS32 sequencer: Moore control FSM sharing one memory port for
// fetch and data, with retire counting and halt on illegal opcode or timeout.
module mips32_multicycle_ctrl #(
  parameter int COUNT_W  = 32,
  parameter int MAX_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic [1:0]         PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               halted,
  output logic               illegal_op,
  output logic               mem_timeout
);

  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_HALT    = 4'd15
  } state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;

  logic mem_state;
  logic wait_limit;
  logic stall_timeout;
  logic retire;

  assign mem_state     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign wait_limit    = (MAX_WAIT > 0) && (wait_q == WAIT_W'(MAX_WAIT));
  // A late mem_ready on the limit cycle still completes the access.
  assign stall_timeout = mem_state && !mem_ready && wait_limit;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADDR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC:    state_d = S_RWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
    if (stall_timeout) begin
      state_d   = S_HALT;
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    if (mem_state && !mem_ready && !stall_timeout) wait_d = wait_q + WAIT_W'(1);
    else                                            wait_d = '0;
    count_d = retire ? count_q + COUNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      default: ;
    endcase
    // Reset must silence the datapath at once, including the Mealy fetch strobes.
    if (!rst) begin
      mem_req     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemToReg    = 1'b0;
    end
  end

  assign state       = rst ? state_q : 4'd0;
  assign instr_count = rst ? count_q : '0;
  assign halted      = rst && (state_q == S_HALT);
  assign illegal_op  = rst && illegal_q;
  assign mem_timeout = rst && timeout_q;

endmodule

// File: doc/mips32_multicycle_ctrl.md
# mips32_multicycle_ctrl

Multicycle sequencing FSM for the MIPS32 core. It replaces the single-cycle opcode decoder with a Moore state machine that drives the datapath control lines state by state. This lets one shared memory port serve both instruction fetch and data access, with wait states. It also maintains a retired-instruction counter and halts cleanly on illegal opcodes or memory timeout.

## Interface
- COUNT_W, 32, width of retired-instruction counter
- MAX_WAIT, 0, max wait cycles per memory access before timeout halt; 0 disables timeout
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes current access this cycle
- mem_req  output  1  memory access in progress
- MemRead, MemWrite, IorD, IRWrite  output  1 each  memory/IR control (IorD: 0 = PC, 1 = ALUOut)
- PCWrite, PCWriteCond  output  1 each  unconditional / branch-qualified PC load
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUSrcA  output  1  0 = PC, 1 = reg A
- ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext, 11 = sign-ext<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct
- RegWrite, RegDst, MemToReg  output  1 each  register-file control
- state  output  4  current state, for debug
- instr_count  output  COUNT_W  retired instructions, wraps to 0
- halted  output  1  FSM in HALT
- illegal_op, mem_timeout  output  1 each  sticky halt cause

## Operation
State encoding: FETCH = 0, DECODE = 1, MEMADDR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, ADDIWB = 11, HALT = 15. Any other code goes to HALT.

Outputs are decoded from state. Any signal not listed for a state is 0.

- FETCH: mem_req, MemRead, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00. IRWrite = PCWrite = mem_ready. These two are the only Mealy terms. Go to DECODE when mem_ready = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADDR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - anything else → HALT, and set illegal_op
- MEMADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req, MemRead, IorD = 1. Go to MEMWB when mem_ready = 1.
- MEMWB: RegWrite, MemToReg = 1, RegDst = 0. Go to FETCH.
- MEMWR: mem_req, MemWrite, IorD = 1. Go to FETCH when mem_ready = 1.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Go to RWB.
- RWB: RegWrite, RegDst = 1, MemToReg = 0. Go to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond, PCSource = 01. Go to FETCH.
- JUMP: PCWrite, PCSource = 10. Go to FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Go to ADDIWB.
- ADDIWB: RegWrite, RegDst = 0, MemToReg = 0. Go to FETCH.
- HALT: all controls 0, halted = 1. Exited only by reset.

Retire counting:
- instr_count increments by 1 on each edge that leaves MEMWB, RWB, BRANCH, JUMP or ADDIWB.
- It also increments on the edge that leaves MEMWR with mem_ready = 1.
- It wraps modulo 2^COUNT_W and never counts in HALT.

Wait counter:
- Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready = 0.
- Clears on mem_ready = 1 and on any state change.
- If MAX_WAIT > 0 and the counter reaches MAX_WAIT with mem_ready still 0, go to HALT at the next edge and set mem_timeout.
- mem_ready = 1 in the same cycle as the limit wins: no timeout.

## Timing
Reset:
- While rst = 0, all outputs are forced 0 combinationally.
- The state register is held at FETCH; instr_count, the wait counter, illegal_op and mem_timeout are 0.
- Reset asserted mid-instruction aborts the instruction immediately, with no further writes.
- The first mem_req rises in the first cycle with rst = 1.

Latency in cycles with zero-wait memory (mem_ready tied 1):
- lw 5
- sw 4
- R-type 4
- addi 4
- beq 3
- j 3

Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds 1 cycle.

Handshake rules:
- mem_req, MemRead/MemWrite and IorD stay stable until the cycle mem_ready = 1.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- PCWrite and IRWrite pulse for exactly 1 cycle per fetch.

## Test plan
- Reset, mem_ready = 1, opcode sequence 000000, 100011, 101011, 000100, 000010, 001000 → state traces 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11. instr_count = 6 after 23 cycles.
- lw with mem_ready low for 3 cycles in MEMRD → mem_req, MemRead and IorD = 1 held for 4 cycles, and MEMWB is entered on the edge after mem_ready. lw total is 8 cycles.
- Opcode 111111 at DECODE → HALT next edge, halted = 1 and illegal_op = 1. All controls stay 0 for 10 further cycles and instr_count is unchanged.
- MAX_WAIT = 4, mem_ready held 0 in FETCH → HALT after 4 wait cycles with mem_timeout = 1. A repeat run with mem_ready rising exactly at the limit cycle → no timeout.
- rst pulled low for 1 cycle while in MEMWR with mem_ready = 0 → outputs 0 immediately, MemWrite never completes, FETCH resumes with instr_count = 0.
- COUNT_W = 4, 17 j instructions → instr_count wraps 15 → 0 → 1.
